// File: rtl/mux_serializer_if.sv
// Load/serial handshake bundle between the serializer and its neighbours.
// The master side is the serializer: it consumes din/load_valid/ser_ready
// and drives the serial stream, the mux select index and status flags.
interface mux_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic [CW-1:0]    sel_out;
    logic             busy;
    logic             done;

    modport master (
        input  din,
        input  load_valid,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output sel_out,
        output busy,
        output done
    );

    modport slave (
        output din,
        output load_valid,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  sel_out,
        input  busy,
        input  done
    );
endinterface

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage feeding a 2:1 mux tree. A word is captured on the
// load handshake, then one bit per accepted beat is presented on ser_out
// while sel_out carries the bit index used as the downstream mux select.
// A single FIN cycle pulses done before the block returns to IDLE.
module mux_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    mux_serializer_if.master  bus
);
    localparam int CW = $clog2(WIDTH);
    // Index of the final beat; cnt never moves past this value.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q,  hold_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [CW-1:0]    sel;

    // State, captured word and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the word holding register is a handful of flops, not a
            // memory, so it is reset like everything else; this keeps ser_out
            // deterministic even before the first load.
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load in IDLE, step per accepted beat in SEND,
    // single-cycle FIN, with clr overriding everything.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no
        // latch is inferred.
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        if (clr) begin
            // Abort: the held word is kept but never driven out again.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // load_ready is 1 throughout IDLE, so valid alone is the
                    // handshake.
                    if (bus.load_valid) begin
                        hold_d  = bus.din;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    // ser_valid is 1 throughout SEND; a beat completes when
                    // the downstream takes it.
                    if (bus.ser_ready) begin
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = FIN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Bit index presented to the mux tree; the counter always runs upward
    // and the direction is folded in here.
    assign sel = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

    // All outputs decode registered state only, so no input reaches an
    // output combinationally.
    assign bus.load_ready = (state_q == IDLE);
    assign bus.ser_valid  = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.done       = (state_q == FIN);
    assign bus.sel_out    = sel;
    assign bus.ser_out    = (state_q == SEND) ? hold_q[sel] : 1'b0;

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the 2:1 mux tree and generates its select signals.
- Captures a WIDTH-bit word via a valid/ready load handshake.
- Steps a bit index (sel_out) across the word, presenting one bit per accepted beat on ser_out with a valid/ready handshake.
- Pulses done after the last bit; used for LED/shift-register/UART-style lab outputs.

Parameters:
- WIDTH, 8: bits per word; legal range 2..256.
- MSB_FIRST, 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.
- CW, $clog2(WIDTH): width of the index counter and of sel_out. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; returns to IDLE, takes priority over all other inputs.
- din  input  WIDTH  parallel word to serialize.
- load_valid  input  1  din is valid.
- load_ready  output  1  block can accept a word.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- sel_out  output  CW  current bit index; drives downstream mux selects.
- busy  output  1  word in flight.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, hold=0, cnt=0, done=0.
  - load_ready=1, ser_valid=0, busy=0, sel_out=0, ser_out=0.
- Outputs:
  - load_ready=(state==IDLE); ser_valid=busy=(state==SEND).
  - sel_out = MSB_FIRST ? WIDTH-1-cnt : cnt.
  - ser_out = hold[sel_out] in SEND, 0 otherwise.
  - All outputs are decoded from registers only; there is no combinational path from any input to any output.
- States: IDLE, SEND, FIN.
- IDLE:
  - load_valid & load_ready: hold<=din, cnt<=0, go SEND.
  - First bit is visible on the next cycle (load-to-first-bit latency 1).
- SEND:
  - ser_valid & ser_ready with cnt<WIDTH-1: cnt<=cnt+1.
  - ser_valid & ser_ready with cnt==WIDTH-1: go FIN, cnt<=0.
  - ser_ready=0: hold the state. ser_out and sel_out stay stable until the bit is accepted.
  - hold never changes in SEND; din changes are ignored.
- FIN:
  - done=1 for exactly this one cycle; load_ready=0.
  - Unconditionally go IDLE next cycle.
- Timing: minimum word period is WIDTH+2 cycles (load, WIDTH beats, FIN). A word fully stalled by ser_ready takes arbitrarily long.
- Counter rules:
  - cnt never exceeds WIDTH-1.
  - For non-power-of-2 WIDTH, sel_out never takes values >= WIDTH.
- clr:
  - In any state, state<=IDLE and cnt<=0; no done pulse. hold is kept but is never driven out.
  - clr and load_valid in the same IDLE cycle: clr wins, no capture.
- Reset mid-word: word is abandoned and all outputs immediately take their reset values (asynchronous).
- load_valid while not IDLE is ignored; the source must hold it until load_ready=1.

Test Plan:
- Reset with WIDTH=8, MSB_FIRST=0 -> load_ready=1, ser_valid=0, sel_out=0, done=0. Load din=8'hA5 with ser_ready=1 -> ser_out sequence 1,0,1,0,0,1,0,1 with sel_out 0..7. done pulses in the cycle after the sel_out=7 beat. load_ready=1 one cycle later.
- MSB_FIRST=1, din=8'h81 -> sel_out 7,6,...,0; ser_out 1,0,0,0,0,0,0,1.
- Backpressure: din=8'h0F, ser_ready low for 3 cycles at sel_out=2 -> ser_out=1 and sel_out=2 held for 3 cycles. No bit lost. Total 8 accepted beats, single done pulse.
- Abort: assert clr at sel_out=4 -> next cycle IDLE, load_ready=1, no done. A new load of 8'hFF then sends eight 1s starting at sel_out=0.
- Async reset mid-word (rst at sel_out=3, between clock edges) -> ser_valid=0, sel_out=0, busy=0 before the next edge.
- WIDTH=5 back-to-back loads 5'h15 then 5'h0A with load_valid held high -> sel_out stays within 0..4. Serial stream is 1,0,1,0,1, then 0,1,0,1,0. Exactly two done pulses. Word period is 7 cycles.
